// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_pkg
//  Description : Shared op codes, FSM state type and iteration-count helper
//                for the multi-cycle multiply/divide unit.
//  Revision    : 1.0 - initial release
// ============================================================================
package muldiv_pkg;

    // Operation codes; code 7 is unused and behaves as a NOP.
    localparam logic [2:0] OP_NOP   = 3'd0;
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_e;

    // Number of CALC cycles: one quotient bit per cycle for divide,
    // bpc multiplier bits per cycle for multiply.
    function automatic int iter_count(input int width, input int bpc, input logic is_div);
        return is_div ? width : (width / bpc);
    endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_if.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_if
//  Description : Request/response bundle between the EX stage and the
//                multiply/divide unit (handshake, operands, HI/LO).
//  Revision    : 1.0 - initial release
// ============================================================================
interface muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic             flush;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             start_ack;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, flush, a, b,
        input  start_ack, busy, done, hi, lo
    );

    modport slave (
        input  start, op, flush, a, b,
        output start_ack, busy, done, hi, lo
    );
endinterface
`default_nettype wire

// File: rtl/muldiv_datapath.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_datapath
//  Description : Operand capture, radix-2^MUL_BPC shift-add multiplier,
//                restoring divider and final two's-complement sign fixup.
//  Revision    : 1.0 - initial release
// ============================================================================
module muldiv_datapath #(
    parameter int WIDTH   = 32,
    parameter int MUL_BPC = 2
) (
    input  wire logic             clk,
    input  wire logic             rst,        // active-low, asynchronous
    input  wire logic             load,       // capture operands for a new op
    input  wire logic             is_div,
    input  wire logic             is_signed,
    input  wire logic [WIDTH-1:0] a,
    input  wire logic [WIDTH-1:0] b,
    input  wire logic             step,       // perform one iteration
    output logic      [WIDTH-1:0] res_hi,
    output logic      [WIDTH-1:0] res_lo
);
    localparam int c_acc_w = 2 * WIDTH;
    localparam int c_pp_w  = WIDTH + MUL_BPC;

    // acc holds {partial product, unconsumed multiplier} for multiply and
    // {remainder, dividend/quotient} for divide.
    logic [c_acc_w-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opb_q, opb_d;        // multiplicand or divisor magnitude
    logic               is_div_q, is_div_d;
    logic               neg_res_q, neg_res_d; // operand signs differ
    logic               neg_rem_q, neg_rem_d; // dividend was negative
    logic               div_zero_q, div_zero_d;

    logic               w_a_neg, w_b_neg;
    logic [WIDTH-1:0]   w_a_mag, w_b_mag;
    logic [c_pp_w-1:0]  w_pp, w_sum;
    logic [c_acc_w-1:0] w_acc_mul, w_acc_div, w_prod;
    logic [WIDTH:0]     w_shifted;
    logic [WIDTH-1:0]   w_diff, w_rem_next, w_quo, w_rem;
    logic               w_qbit;

    // Next-state for the iteration registers: capture, multiply step or divide step.
    always_comb begin
        acc_d      = acc_q;
        opb_d      = opb_q;
        is_div_d   = is_div_q;
        neg_res_d  = neg_res_q;
        neg_rem_d  = neg_rem_q;
        div_zero_d = div_zero_q;

        w_a_neg = is_signed & a[WIDTH-1];
        w_b_neg = is_signed & b[WIDTH-1];
        w_a_mag = w_a_neg ? -a : a;
        w_b_mag = w_b_neg ? -b : b;

        // Multiply: add digit * multiplicand to the upper half, then shift the
        // whole accumulator right by one digit.
        w_pp = '0;
        for (int i = 0; i < MUL_BPC; i++) begin
            if (acc_q[i]) begin
                w_pp = w_pp + (c_pp_w'(opb_q) << i);
            end
        end
        w_sum     = c_pp_w'(acc_q[c_acc_w-1:WIDTH]) + w_pp;
        w_acc_mul = c_acc_w'({w_sum, acc_q[WIDTH-1:0]} >> MUL_BPC);

        // Divide: shift in the next dividend bit, keep the difference only
        // when it does not go negative.
        w_shifted  = {acc_q[c_acc_w-1:WIDTH], acc_q[WIDTH-1]};
        w_diff     = w_shifted[WIDTH-1:0] - opb_q;
        w_qbit     = (w_shifted >= {1'b0, opb_q});
        w_rem_next = w_qbit ? w_diff : w_shifted[WIDTH-1:0];
        w_acc_div  = {w_rem_next, acc_q[WIDTH-2:0], w_qbit};

        if (load) begin
            is_div_d   = is_div;
            neg_res_d  = w_a_neg ^ w_b_neg;
            neg_rem_d  = w_a_neg;
            div_zero_d = (b == '0);
            opb_d      = is_div ? w_b_mag : w_a_mag;
            acc_d      = {{WIDTH{1'b0}}, (is_div ? w_a_mag : w_b_mag)};
        end else if (step) begin
            acc_d = is_div_q ? w_acc_div : w_acc_mul;
        end
    end

    // Sign fixup of the finished magnitude result, consumed during FIX.
    always_comb begin
        w_prod = neg_res_q ? -acc_q : acc_q;
        w_quo  = acc_q[WIDTH-1:0];
        w_rem  = acc_q[c_acc_w-1:WIDTH];
        if (is_div_q) begin
            // A zero divisor yields an all-ones quotient regardless of sign;
            // the remainder path already reproduces the dividend.
            res_lo = div_zero_q ? '1 : (neg_res_q ? -w_quo : w_quo);
            res_hi = neg_rem_q ? -w_rem : w_rem;
        end else begin
            res_hi = w_prod[c_acc_w-1:WIDTH];
            res_lo = w_prod[WIDTH-1:0];
        end
    end

    // Iteration register file.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q      <= '0;
            opb_q      <= '0;
            is_div_q   <= 1'b0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            acc_q      <= acc_d;
            opb_q      <= opb_d;
            is_div_q   <= is_div_d;
            neg_res_q  <= neg_res_d;
            neg_rem_q  <= neg_rem_d;
            div_zero_q <= div_zero_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_unit
//  Description : Multi-cycle multiply/divide unit with private HI/LO
//                registers, start handshake and flush/abort.
//  Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int MUL_BPC = 2
) (
    input  wire logic clk,
    input  wire logic rst,       // active-low, asynchronous
    muldiv_if.slave   bus
);
    localparam int c_cnt_w = $clog2(WIDTH) + 1;

    state_e             state_q, state_d;
    logic [c_cnt_w-1:0] cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic               w_op_valid, w_arith, w_is_div, w_is_signed;
    logic               w_accept, w_load, w_step;
    logic [WIDTH-1:0]   w_res_hi, w_res_lo;

    // Op decode and start handshake.
    always_comb begin
        w_op_valid  = (bus.op != OP_NOP) && (bus.op <= OP_MTLO);
        w_is_div    = (bus.op == OP_DIV)  || (bus.op == OP_DIVU);
        w_is_signed = (bus.op == OP_MULT) || (bus.op == OP_DIV);
        w_arith     = w_is_div || (bus.op == OP_MULT) || (bus.op == OP_MULTU);
        w_accept    = bus.start && !busy_q && !bus.flush && w_op_valid;
        w_load      = w_accept && w_arith;
        w_step      = (state_q == CALC);
    end

    assign bus.start_ack = w_accept;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.hi        = hi_q;
    assign bus.lo        = lo_q;

    muldiv_datapath #(
        .WIDTH   (WIDTH),
        .MUL_BPC (MUL_BPC)
    ) u_datapath (
        .clk       (clk),
        .rst       (rst),
        .load      (w_load),
        .is_div    (w_is_div),
        .is_signed (w_is_signed),
        .a         (bus.a),
        .b         (bus.b),
        .step      (w_step),
        .res_hi    (w_res_hi),
        .res_lo    (w_res_lo)
    );

    // Next state, iteration counter and HI/LO update.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (w_accept) begin
                    if (bus.op == OP_MTHI) begin
                        hi_d = bus.a;
                    end else if (bus.op == OP_MTLO) begin
                        lo_d = bus.a;
                    end else begin
                        state_d = CALC;
                        cnt_d   = c_cnt_w'(iter_count(WIDTH, MUL_BPC, w_is_div));
                    end
                end
            end
            CALC: begin
                if (bus.flush) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == c_cnt_w'(1)) begin
                        state_d = FIX;
                    end
                end
            end
            FIX: begin
                state_d = IDLE;
                if (!bus.flush) begin
                    hi_d   = w_res_hi;
                    lo_d   = w_res_lo;
                    done_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    // Control and architectural register state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_muldiv_unit
//  Description : Self-checking bench for muldiv_unit: directed corner cases,
//                flush/reset scenarios and randomized ops vs. an arithmetic
//                reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int WIDTH   = 32;
    localparam int MUL_BPC = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    muldiv_if #(.WIDTH(WIDTH)) bus ();

    muldiv_unit #(
        .WIDTH   (WIDTH),
        .MUL_BPC (MUL_BPC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference results straight from integer arithmetic.
    function automatic void ref_model(input logic [2:0] op, input logic [31:0] a,
                                      input logic [31:0] b,
                                      output logic [31:0] hi, output logic [31:0] lo);
        logic [63:0] p;
        longint      sa, sb, q, r;
        hi = '0;
        lo = '0;
        case (op)
            OP_MULT: begin
                p  = longint'($signed(a)) * longint'($signed(b));
                hi = p[63:32];
                lo = p[31:0];
            end
            OP_MULTU: begin
                p  = {32'b0, a} * {32'b0, b};
                hi = p[63:32];
                lo = p[31:0];
            end
            OP_DIV: begin
                if (b == 0) begin
                    lo = 32'hFFFF_FFFF;
                    hi = a;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    lo = 32'h8000_0000;
                    hi = 32'h0;
                end else begin
                    sa = longint'($signed(a));
                    sb = longint'($signed(b));
                    q  = sa / sb;
                    r  = sa % sb;
                    lo = 32'(q);
                    hi = 32'(r);
                end
            end
            OP_DIVU: begin
                if (b == 0) begin
                    lo = 32'hFFFF_FFFF;
                    hi = a;
                end else begin
                    lo = a / b;
                    hi = a % b;
                end
            end
            default: ;
        endcase
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 4))
            0:       return 32'($urandom_range(0, 20));
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Issue one MULT/DIV op and check handshake, latency, busy window and result.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
        int  n_iter;
        int  lat;
        int  busy_cnt;
        bit  got;
        n_iter = ((op == OP_DIV) || (op == OP_DIVU)) ? WIDTH : WIDTH / MUL_BPC;
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        #1;
        check($sformatf("%s ack", tag), 64'(bus.start_ack), 64'd1);
        @(posedge clk);
        lat      = -1;
        busy_cnt = 0;
        got      = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (bus.done) begin
                lat = k;
                got = 1'b1;
                break;
            end
            if (bus.busy) busy_cnt++;
        end
        check($sformatf("%s latency", tag), 64'(lat), 64'(n_iter + 1));
        if (got) begin
            check($sformatf("%s busy_cycles", tag), 64'(busy_cnt), 64'(n_iter + 1));
            check($sformatf("%s hi", tag), 64'(bus.hi), 64'(ehi));
            check($sformatf("%s lo", tag), 64'(bus.lo), 64'(elo));
            @(negedge clk);
            check($sformatf("%s done_pulse", tag), 64'(bus.done), 64'd0);
        end
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a, b, hi, lo;
    } vec_t;

    vec_t dir_vecs [5] = '{
        '{OP_MULT, 32'hFFFF_FFFD, 32'd5,        32'hFFFF_FFFF, 32'hFFFF_FFF1},
        '{OP_DIVU, 32'd100,       32'd7,        32'd2,         32'd14},
        '{OP_DIV,  32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD},
        '{OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0,        32'h8000_0000},
        '{OP_DIVU, 32'h0000_1234, 32'h0,        32'h0000_1234, 32'hFFFF_FFFF}
    };

    initial begin
        logic [2:0]  rop;
        logic [31:0] ra, rb, ehi, elo;
        int          done_seen;

        bus.start = 1'b0;
        bus.op    = OP_NOP;
        bus.flush = 1'b0;
        bus.a     = '0;
        bus.b     = '0;

        // Reset state
        #2 rst = 1'b0;
        #1;
        check("reset hi",   64'(bus.hi),   64'd0);
        check("reset lo",   64'(bus.lo),   64'd0);
        check("reset busy", 64'(bus.busy), 64'd0);
        check("reset done", 64'(bus.done), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // NOP and code 7 are never acknowledged
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = OP_NOP;
        #1 check("nop ack", 64'(bus.start_ack), 64'd0);
        bus.op = 3'd7;
        #1 check("op7 ack", 64'(bus.start_ack), 64'd0);
        @(negedge clk);
        bus.start = 1'b0;
        check("op7 busy", 64'(bus.busy), 64'd0);

        // Directed corner cases
        foreach (dir_vecs[i]) begin
            run_op($sformatf("dir%0d", i), dir_vecs[i].op, dir_vecs[i].a, dir_vecs[i].b,
                   dir_vecs[i].hi, dir_vecs[i].lo);
        end

        // MTHI / MTLO
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = OP_MTHI;
        bus.a     = 32'hA5A5_A5A5;
        #1 check("mthi ack", 64'(bus.start_ack), 64'd1);
        @(negedge clk);
        bus.op = OP_MTLO;
        bus.a  = 32'h5A5A_5A5A;
        check("mthi hi",   64'(bus.hi),   64'hA5A5_A5A5);
        check("mthi busy", 64'(bus.busy), 64'd0);
        @(negedge clk);
        bus.start = 1'b0;
        check("mtlo lo",   64'(bus.lo),   64'h5A5A_5A5A);
        check("mtlo busy", 64'(bus.busy), 64'd0);
        check("mtlo done", 64'(bus.done), 64'd0);

        // Flush in the same cycle as start wins
        @(negedge clk);
        bus.start = 1'b1;
        bus.flush = 1'b1;
        bus.op    = OP_MTHI;
        bus.a     = 32'h1111_1111;
        #1 check("flush+start ack", 64'(bus.start_ack), 64'd0);
        @(negedge clk);
        bus.start = 1'b0;
        bus.flush = 1'b0;
        check("flush+start hi", 64'(bus.hi), 64'hA5A5_A5A5);

        // MULTU aborted by flush; a second start while busy is ignored
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = OP_MULTU;
        bus.a     = 32'd6;
        bus.b     = 32'd7;
        #1 check("flush op ack", 64'(bus.start_ack), 64'd1);
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = OP_MULT;
        bus.a     = 32'd3;
        bus.b     = 32'd3;
        #1 check("busy start ack", 64'(bus.start_ack), 64'd0);
        check("busy during op", 64'(bus.busy), 64'd1);
        @(negedge clk);
        bus.start = 1'b0;
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        check("flush busy", 64'(bus.busy), 64'd0);
        done_seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.done) done_seen++;
        end
        check("flush no done", 64'(done_seen), 64'd0);
        check("flush hi kept", 64'(bus.hi), 64'hA5A5_A5A5);
        check("flush lo kept", 64'(bus.lo), 64'h5A5A_5A5A);

        // Randomized ops against the reference model
        for (int i = 0; i < 40; i++) begin
            rop = 3'($urandom_range(1, 4));
            ra  = pick();
            rb  = pick();
            ref_model(rop, ra, rb, ehi, elo);
            run_op($sformatf("rnd%0d op%0d a=%0h b=%0h", i, rop, ra, rb), rop, ra, rb, ehi, elo);
        end

        // Reset in the middle of a divide
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = OP_DIVU;
        bus.a     = 32'd1000;
        bus.b     = 32'd3;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (8) @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst hi",   64'(bus.hi),   64'd0);
        check("midrst lo",   64'(bus.lo),   64'd0);
        check("midrst busy", 64'(bus.busy), 64'd0);
        check("midrst done", 64'(bus.done), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        done_seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.done) done_seen++;
        end
        check("midrst no done", 64'(done_seen), 64'd0);
        run_op("post-rst multu", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
               32'hFFFF_FFFE, 32'h0000_0001);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Parametrised multi-cycle multiply/divide unit with its own HI/LO registers.
- Replaces the single-cycle 64-bit product path in the EX-stage ALU.
- Sits beside the ALU in EX. The pipeline stalls on `busy`. The ID stage reads `hi`/`lo` for MFHI/MFLO.
- Adds iterative division, exception flush/abort, a start handshake and configurable multiplier throughput.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- MUL_BPC, 2, multiplier bits retired per cycle; must divide WIDTH exactly.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  request a new operation.
- op  in  3  operation code; encodings in the shared package.
- flush  in  1  exception/flush; aborts any in-flight operation.
- a  in  WIDTH  rs operand; also the source value for MTHI/MTLO.
- b  in  WIDTH  rt operand.
- start_ack  out  1  combinational: start && !busy && !flush && op != OP_NOP.
- busy  out  1  registered; high while in CALC or FIX.
- done  out  1  registered; one-cycle pulse when hi/lo are updated by MULT/DIV.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset (rst low, asynchronous): state=IDLE; busy=0; done=0; hi=0; lo=0; counter=0.
- States:
  - IDLE → CALC on an accepted MULT/MULTU/DIV/DIVU.
  - CALC → FIX after the final iteration.
  - FIX → IDLE.
- MTHI/MTLO are accepted in IDLE only.
  - On the accepting edge, hi (or lo) <= a.
  - No busy, no done; state stays IDLE.
- Operand capture on the accepting edge:
  - Signed ops store absolute values plus result-sign flags.
  - Unsigned ops store raw values.
- MULT/MULTU:
  - Radix-2^MUL_BPC shift-add; WIDTH/MUL_BPC cycles in CALC.
  - The 2*WIDTH-bit product is formed in the accumulator.
- DIV/DIVU:
  - Restoring division, 1 quotient bit per cycle; WIDTH cycles in CALC.
- FIX (1 cycle): applies two's-complement sign correction.
  - Product is negated if the operand signs differ.
  - Quotient is negated if the operand signs differ.
  - Remainder takes the sign of the dividend.
- Result loading:
  - On the edge leaving FIX: {hi,lo} <= product, or hi <= remainder, lo <= quotient.
  - In the following cycle: done=1, busy=0.
- Latency from accepting edge to hi/lo update:
  - MUL: WIDTH/MUL_BPC + 1 edges (17 at defaults).
  - DIV: WIDTH + 1 edges (33 at defaults).
- busy is high from the cycle after the accepting edge until and including the FIX cycle.
- Start while busy: ignored; start_ack=0; nothing queued.
- Flush:
  - Same cycle as start: flush wins; nothing is accepted.
  - In CALC/FIX: next edge returns to IDLE; hi/lo unchanged; no done.
  - In IDLE: no effect.
- Divide by zero (b==0): completes with normal latency; lo = all ones; hi = a unchanged. Applies to signed and unsigned.
- Signed overflow (a = most negative, b = -1): lo = most negative, hi = 0.
- Counter width is $clog2(WIDTH)+1; the counter loads on accept and decrements in CALC.
- Reset asserted mid-operation: immediate return to reset values; no done.

Decomposition:
- Package muldiv_pkg holds:
  - op codes: OP_NOP=0, OP_MULT=1, OP_MULTU=2, OP_DIV=3, OP_DIVU=4, OP_MTHI=5, OP_MTLO=6; codes 7 are treated as NOP.
  - state enum: IDLE, CALC, FIX.
  - helper function for the iteration count.
- One natural sub-module, muldiv_datapath:
  - contains the accumulator/remainder registers, the shift-add and restore-subtract logic, and the sign fixup.
  - the top level keeps the FSM, counter, handshake and HI/LO registers.

Test Plan (WIDTH=32, MUL_BPC=2):
- MULT a=0xFFFFFFFD (-3), b=5 → start_ack=1; busy for 17 cycles; done pulse; hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- DIVU a=100, b=7 → done at edge 33; lo=14, hi=2.
- DIV a=-7, b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0.
- DIVU a=0x1234, b=0 → lo=0xFFFFFFFF, hi=0x1234.
- MTHI a=0xA5A5A5A5 then MTLO a=0x5A5A5A5A → hi/lo updated on the next edge each; busy never set.
- Start MULTU 6×7, then flush at cycle 5 → idle next cycle; hi/lo keep prior values; no done. A second start during the busy window gets start_ack=0.
- Assert rst low mid-DIV → hi=lo=0 and busy=0 immediately. After release, MULTU 0xFFFFFFFF×0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001.
